// File: rtl/pipe_pkg.sv
// Shared ISA constants and controller state encoding for the 5-stage core.
// Used by the ID-stage decoder, the sequencing controller and the hazard logic.
package pipe_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SLT  = 4'b0101;
   localparam logic [3:0] OP_ADDI = 4'b0110;
   localparam logic [3:0] OP_LW   = 4'b0111;
   localparam logic [3:0] OP_SW   = 4'b1000;
   localparam logic [3:0] OP_BEQ  = 4'b1001;
   localparam logic [3:0] OP_BNE  = 4'b1010;
   localparam logic [3:0] OP_JMP  = 4'b1011;
   localparam logic [3:0] OP_NOP  = 4'b1111;
   localparam logic [3:0] HALT_OP = 4'b1110;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;
   localparam logic [2:0] ALU_SLT = 3'd5;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      DRAIN    = 2'd2,
      HALTED   = 2'd3
   } ctrl_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Register-compare hazard check between the ID sources and the EX destination.
// Tie i_exReadMem high to reuse it as a plain RAW match for forwarding.
module load_use_detect
   import pipe_pkg::*;
#(
   parameter int ADDR_W = 3
) (
   input  logic              i_idValid,
   input  logic [ADDR_W-1:0] i_idRs,
   input  logic [ADDR_W-1:0] i_idRt,
   input  logic              i_idUsesRs,
   input  logic              i_idUsesRt,
   input  logic              i_exReadMem,
   input  logic              i_exWriteReg,
   input  logic [ADDR_W-1:0] i_exRd,
   output logic              o_hazard
);

   logic w_rsMatch;
   logic w_rtMatch;

   assign w_rsMatch = i_idUsesRs && (i_idRs == i_exRd);
   assign w_rtMatch = i_idUsesRt && (i_idRt == i_exRd);
   assign o_hazard  = i_idValid && i_exReadMem && i_exWriteReg && (w_rsMatch || w_rtMatch);

endmodule

// File: rtl/pipeline_ctrl.sv
// Sequencing controller: per-stage enables/flushes from hazards, run/halt state
// and a stall performance counter for the 5-stage core.
module pipeline_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_ADDR_W   = 3,
   parameter int DRAIN_CYCLES = 3,
   parameter int MEM_TIMEOUT  = 15,
   parameter int STALL_CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   id_valid,
   input  logic [3:0]             id_opcode,
   input  logic [REG_ADDR_W-1:0]  id_rs,
   input  logic [REG_ADDR_W-1:0]  id_rt,
   input  logic                   id_uses_rs,
   input  logic                   id_uses_rt,
   input  logic                   ex_read_mem,
   input  logic                   ex_write_reg,
   input  logic [REG_ADDR_W-1:0]  ex_rd,
   input  logic                   ex_redirect,
   input  logic                   mem_access,
   input  logic                   mem_ready,
   output logic                   pc_en,
   output logic                   pc_sel_redirect,
   output logic                   ifid_en,
   output logic                   idex_en,
   output logic                   exmem_en,
   output logic                   memwb_en,
   output logic                   ifid_flush,
   output logic                   idex_flush,
   output logic                   halted,
   output logic                   mem_error,
   output logic [STALL_CNT_W-1:0] stall_count
);

   localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
   localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);

   ctrl_state_t            r_state;
   ctrl_state_t            w_nextState;
   logic [DRAIN_W-1:0]     r_drainCnt;
   logic [DRAIN_W-1:0]     w_nextDrainCnt;
   logic [WAIT_W-1:0]      r_waitCnt;
   logic [WAIT_W-1:0]      w_nextWaitCnt;
   logic                   r_retDrain;
   logic                   w_nextRetDrain;
   logic                   r_halted;
   logic                   r_memError;
   logic [STALL_CNT_W-1:0] r_stallCount;

   logic w_hazard;
   logic w_freeze;
   logic w_effRun;
   logic w_effDrain;
   logic w_redirect;
   logic w_haltId;
   logic w_loadUse;
   logic w_drainStep;
   logic w_enterHalted;
   logic w_setError;
   logic w_countStall;

   load_use_detect #(
      .ADDR_W(REG_ADDR_W)
   ) u_loadUse (
      .i_idValid   (id_valid),
      .i_idRs      (id_rs),
      .i_idRt      (id_rt),
      .i_idUsesRs  (id_uses_rs),
      .i_idUsesRt  (id_uses_rt),
      .i_exReadMem (ex_read_mem),
      .i_exWriteReg(ex_write_reg),
      .i_exRd      (ex_rd),
      .o_hazard    (w_hazard)
   );

   // An unfrozen MEM_WAIT cycle behaves like the state it was entered from.
   assign w_freeze    = mem_access && !mem_ready && (r_state != HALTED);
   assign w_effRun    = (r_state == RUN)   || ((r_state == MEM_WAIT) && !r_retDrain);
   assign w_effDrain  = (r_state == DRAIN) || ((r_state == MEM_WAIT) &&  r_retDrain);
   assign w_redirect  = w_effRun && !w_freeze && ex_redirect;
   assign w_haltId    = w_effRun && !w_freeze && !ex_redirect && id_valid && (id_opcode == HALT_OP);
   assign w_loadUse   = w_effRun && !w_freeze && !ex_redirect && !w_haltId && w_hazard;
   assign w_drainStep = w_effDrain && !w_freeze;

   always_comb begin
      pc_en           = 1'b0;
      pc_sel_redirect = 1'b0;
      ifid_en         = 1'b0;
      idex_en         = 1'b0;
      exmem_en        = 1'b0;
      memwb_en        = 1'b0;
      ifid_flush      = 1'b0;
      idex_flush      = 1'b0;
      if (rst_n) begin
         if (w_redirect) begin
            pc_en           = 1'b1;
            pc_sel_redirect = 1'b1;
            ifid_en         = 1'b1;
            idex_en         = 1'b1;
            exmem_en        = 1'b1;
            memwb_en        = 1'b1;
            ifid_flush      = 1'b1;
            idex_flush      = 1'b1;
         end else if (w_haltId || w_loadUse || w_drainStep) begin
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            idex_flush = 1'b1;
         end else if (w_effRun && !w_freeze) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
         end
      end
   end

   always_comb begin
      w_nextState    = r_state;
      w_nextDrainCnt = r_drainCnt;
      w_nextWaitCnt  = r_waitCnt;
      w_nextRetDrain = r_retDrain;
      w_enterHalted  = 1'b0;
      w_setError     = 1'b0;
      case (r_state)
         RUN: begin
            if (w_freeze) begin
               w_nextState    = MEM_WAIT;
               w_nextWaitCnt  = WAIT_W'(1);
               w_nextRetDrain = 1'b0;
            end else if (w_haltId) begin
               w_nextState    = DRAIN;
               w_nextDrainCnt = DRAIN_W'(DRAIN_CYCLES);
            end
         end
         MEM_WAIT: begin
            if (w_freeze) begin
               if (r_waitCnt >= WAIT_W'(MEM_TIMEOUT)) begin
                  w_nextState   = HALTED;
                  w_enterHalted = 1'b1;
                  w_setError    = 1'b1;
               end else begin
                  w_nextWaitCnt = r_waitCnt + WAIT_W'(1);
               end
            end else begin
               w_nextWaitCnt = '0;
               if (r_retDrain) begin
                  if (r_drainCnt <= DRAIN_W'(1)) begin
                     w_nextState    = HALTED;
                     w_nextDrainCnt = '0;
                     w_enterHalted  = 1'b1;
                  end else begin
                     w_nextState    = DRAIN;
                     w_nextDrainCnt = r_drainCnt - DRAIN_W'(1);
                  end
               end else if (w_haltId) begin
                  w_nextState    = DRAIN;
                  w_nextDrainCnt = DRAIN_W'(DRAIN_CYCLES);
               end else begin
                  w_nextState = RUN;
               end
            end
         end
         DRAIN: begin
            if (w_freeze) begin
               w_nextState    = MEM_WAIT;
               w_nextWaitCnt  = WAIT_W'(1);
               w_nextRetDrain = 1'b1;
            end else if (r_drainCnt <= DRAIN_W'(1)) begin
               w_nextState    = HALTED;
               w_nextDrainCnt = '0;
               w_enterHalted  = 1'b1;
            end else begin
               w_nextDrainCnt = r_drainCnt - DRAIN_W'(1);
            end
         end
         HALTED: begin
            w_nextState = HALTED;
         end
         default: begin
            w_nextState = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= RUN;
         r_drainCnt <= '0;
         r_waitCnt  <= '0;
         r_retDrain <= 1'b0;
         r_halted   <= 1'b0;
         r_memError <= 1'b0;
      end else begin
         r_state    <= w_nextState;
         r_drainCnt <= w_nextDrainCnt;
         r_waitCnt  <= w_nextWaitCnt;
         r_retDrain <= w_nextRetDrain;
         r_halted   <= r_halted | w_enterHalted;
         r_memError <= r_memError | w_setError;
      end
   end

   // DRAIN and HALTED cycles are intentional idling, not stalls.
   assign w_countStall = ((r_state == RUN) || (r_state == MEM_WAIT)) && !pc_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stallCount <= '0;
      end else if (w_countStall && (r_stallCount != {STALL_CNT_W{1'b1}})) begin
         r_stallCount <= r_stallCount + STALL_CNT_W'(1);
      end
   end

   assign halted      = r_halted;
   assign mem_error   = r_memError;
   assign stall_count = r_stallCount;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scenario bench for pipeline_ctrl: expected control vectors are queued as each
// cycle's stimulus is driven and popped/compared at the following falling edge.
module tb_pipeline_ctrl;

   localparam logic [7:0] CTL_ZERO  = 8'b0000_0000;
   localparam logic [7:0] CTL_NORM  = 8'b1011_1100;
   localparam logic [7:0] CTL_STALL = 8'b0001_1101;
   localparam logic [7:0] CTL_REDIR = 8'b1111_1111;
   localparam logic [3:0] HALT_CODE = 4'b1110;

   logic        clk;
   logic        rst_n;
   logic        idValid;
   logic [3:0]  idOpcode;
   logic [2:0]  idRs;
   logic [2:0]  idRt;
   logic        idUsesRs;
   logic        idUsesRt;
   logic        exReadMem;
   logic        exWriteReg;
   logic [2:0]  exRd;
   logic        exRedirect;
   logic        memAccess;
   logic        memReady;
   logic        pcEn;
   logic        pcSelRedirect;
   logic        ifidEn;
   logic        idexEn;
   logic        exmemEn;
   logic        memwbEn;
   logic        ifidFlush;
   logic        idexFlush;
   logic        haltedOut;
   logic        memErrorOut;
   logic [15:0] stallCount;
   logic [25:0] obsVec;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] expStalls = 16'd0;
   string       nameQ[$];
   logic [25:0] vecQ[$];

   pipeline_ctrl #(
      .REG_ADDR_W  (3),
      .DRAIN_CYCLES(3),
      .MEM_TIMEOUT (15),
      .STALL_CNT_W (16)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .id_valid       (idValid),
      .id_opcode      (idOpcode),
      .id_rs          (idRs),
      .id_rt          (idRt),
      .id_uses_rs     (idUsesRs),
      .id_uses_rt     (idUsesRt),
      .ex_read_mem    (exReadMem),
      .ex_write_reg   (exWriteReg),
      .ex_rd          (exRd),
      .ex_redirect    (exRedirect),
      .mem_access     (memAccess),
      .mem_ready      (memReady),
      .pc_en          (pcEn),
      .pc_sel_redirect(pcSelRedirect),
      .ifid_en        (ifidEn),
      .idex_en        (idexEn),
      .exmem_en       (exmemEn),
      .memwb_en       (memwbEn),
      .ifid_flush     (ifidFlush),
      .idex_flush     (idexFlush),
      .halted         (haltedOut),
      .mem_error      (memErrorOut),
      .stall_count    (stallCount)
   );

   assign obsVec = {pcEn, pcSelRedirect, ifidEn, idexEn, exmemEn, memwbEn,
                    ifidFlush, idexFlush, haltedOut, memErrorOut, stallCount};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [25:0] mkExp(input logic [7:0] ctl, input logic h,
                                         input logic err, input logic [15:0] st);
      return {ctl, h, err, st};
   endfunction

   // Idle baseline: no instruction in ID, nothing in EX/MEM.
   task automatic applyStimulus();
      idValid    = 1'b0;
      idOpcode   = 4'b0000;
      idRs       = 3'd0;
      idRt       = 3'd0;
      idUsesRs   = 1'b0;
      idUsesRt   = 1'b0;
      exReadMem  = 1'b0;
      exWriteReg = 1'b0;
      exRd       = 3'd0;
      exRedirect = 1'b0;
      memAccess  = 1'b0;
      memReady   = 1'b1;
   endtask

   task automatic doReset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      applyStimulus();
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      expStalls = 16'd0;
   endtask

   task automatic test_reset();
      string nm;
      logic [25:0] ev;
      for (int c = 0; c < 2; c++) begin
         applyStimulus();
         if (c == 0) begin
            rst_n = 1'b0;
            exRedirect = 1'b1;
            nameQ.push_back("reset_outputs_low");
            vecQ.push_back(mkExp(CTL_ZERO, 1'b0, 1'b0, 16'd0));
         end else begin
            rst_n = 1'b1;
            nameQ.push_back("after_reset_normal");
            vecQ.push_back(mkExp(CTL_NORM, 1'b0, 1'b0, 16'd0));
         end
         @(negedge clk);
         nm = nameQ.pop_front();
         ev = vecQ.pop_front();
         checks++;
         if (obsVec !== ev) begin
            failures++;
            $display("[TB] FAIL %s c%0d: got ctl=%b h=%b err=%b st=%0d, expected ctl=%b h=%b err=%b st=%0d",
                     nm, c, obsVec[25:18], obsVec[17], obsVec[16], obsVec[15:0], ev[25:18], ev[17], ev[16], ev[15:0]);
         end
         @(posedge clk);
         #1;
      end
      expStalls = 16'd0;
   endtask

   task automatic test_load_use();
      string nm;
      logic [25:0] ev;
      doReset();
      for (int c = 0; c < 7; c++) begin
         applyStimulus();
         exReadMem  = 1'b1;
         exWriteReg = 1'b1;
         case (c)
            0: begin
               exRd = 3'd2; idValid = 1'b1; idRs = 3'd2; idUsesRs = 1'b1;
               nameQ.push_back("lu_rs_stall");
               vecQ.push_back(mkExp(CTL_STALL, 1'b0, 1'b0, expStalls));
               expStalls++;
            end
            2: begin
               exRd = 3'd5; idValid = 1'b1; idRs = 3'd5; idRt = 3'd5; idUsesRt = 1'b1;
               nameQ.push_back("lu_rt_stall");
               vecQ.push_back(mkExp(CTL_STALL, 1'b0, 1'b0, expStalls));
               expStalls++;
            end
            3: begin
               exWriteReg = 1'b0; exRd = 3'd4; idValid = 1'b1; idRs = 3'd4; idUsesRs = 1'b1;
               nameQ.push_back("lu_no_write");
               vecQ.push_back(mkExp(CTL_NORM, 1'b0, 1'b0, expStalls));
            end
            4: begin
               exRd = 3'd4; idRs = 3'd4; idUsesRs = 1'b1;
               nameQ.push_back("lu_id_invalid");
               vecQ.push_back(mkExp(CTL_NORM, 1'b0, 1'b0, expStalls));
            end
            5: begin
               exRd = 3'd6; idValid = 1'b1; idRs = 3'd6; idRt = 3'd1; idUsesRt = 1'b1;
               nameQ.push_back("lu_rs_unused");
               vecQ.push_back(mkExp(CTL_NORM, 1'b0, 1'b0, expStalls));
            end
            default: begin
               exReadMem = 1'b0; exWriteReg = 1'b0;
               nameQ.push_back("lu_bubble_normal");
               vecQ.push_back(mkExp(CTL_NORM, 1'b0, 1'b0, expStalls));
            end
         endcase
         @(negedge clk);
         nm = nameQ.pop_front();
         ev = vecQ.pop_front();
         checks++;
         if (obsVec !== ev) begin
            failures++;
            $display("[TB] FAIL %s c%0d: got ctl=%b h=%b err=%b st=%0d, expected ctl=%b h=%b err=%b st=%0d",
                     nm, c, obsVec[25:18], obsVec[17], obsVec[16], obsVec[15:0], ev[25:18], ev[17], ev[16], ev[15:0]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_redirect();
      string nm;
      logic [25:0] ev;
      doReset();
      for (int c = 0; c < 4; c++) begin
         applyStimulus();
         case (c)
            0: begin
               exRedirect = 1'b1; exReadMem = 1'b1; exWriteReg = 1'b1; exRd = 3'd3;
               idValid = 1'b1; idRt = 3'd3; idUsesRt = 1'b1;
               nameQ.push_back("redirect_over_lu");
               vecQ.push_back(mkExp(CTL_REDIR, 1'b0, 1'b0, expStalls));
            end
            1: begin
               exRedirect = 1'b1; idValid = 1'b1; idOpcode = HALT_CODE;
               nameQ.push_back("redirect_over_halt");
               vecQ.push_back(mkExp(CTL_REDIR, 1'b0, 1'b0, expStalls));
            end
            2: begin
               idOpcode = HALT_CODE;
               nameQ.push_back("halt_op_not_valid");
               vecQ.push_back(mkExp(CTL_NORM, 1'b0, 1'b0, expStalls));
            end
            default: begin
               nameQ.push_back("redirect_still_run");
               vecQ.push_back(mkExp(CTL_NORM, 1'b0, 1'b0, expStalls));
            end
         endcase
         @(negedge clk);
         nm = nameQ.pop_front();
         ev = vecQ.pop_front();
         checks++;
         if (obsVec !== ev) begin
            failures++;
            $display("[TB] FAIL %s c%0d: got ctl=%b h=%b err=%b st=%0d, expected ctl=%b h=%b err=%b st=%0d",
                     nm, c, obsVec[25:18], obsVec[17], obsVec[16], obsVec[15:0], ev[25:18], ev[17], ev[16], ev[15:0]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_mem_wait();
      string nm;
      logic [25:0] ev;
      doReset();
      for (int c = 0; c < 7; c++) begin
         applyStimulus();
         if (c < 4) begin
            memAccess = 1'b1; memReady = 1'b0;
            exRedirect = (c == 1);
            nameQ.push_back("mem_freeze");
            vecQ.push_back(mkExp(CTL_ZERO, 1'b0, 1'b0, expStalls));
            expStalls++;
         end else if (c == 4) begin
            memAccess = 1'b1;
            nameQ.push_back("mem_ready_resume");
            vecQ.push_back(mkExp(CTL_NORM, 1'b0, 1'b0, expStalls));
         end else if (c == 5) begin
            exReadMem = 1'b1; exWriteReg = 1'b1; exRd = 3'd7;
            idValid = 1'b1; idRs = 3'd7; idUsesRs = 1'b1;
            nameQ.push_back("mem_back_in_run_lu");
            vecQ.push_back(mkExp(CTL_STALL, 1'b0, 1'b0, expStalls));
            expStalls++;
         end else begin
            nameQ.push_back("mem_after_normal");
            vecQ.push_back(mkExp(CTL_NORM, 1'b0, 1'b0, expStalls));
         end
         @(negedge clk);
         nm = nameQ.pop_front();
         ev = vecQ.pop_front();
         checks++;
         if (obsVec !== ev) begin
            failures++;
            $display("[TB] FAIL %s c%0d: got ctl=%b h=%b err=%b st=%0d, expected ctl=%b h=%b err=%b st=%0d",
                     nm, c, obsVec[25:18], obsVec[17], obsVec[16], obsVec[15:0], ev[25:18], ev[17], ev[16], ev[15:0]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_halt_drain();
      string nm;
      logic [25:0] ev;
      doReset();
      for (int c = 0; c < 7; c++) begin
         applyStimulus();
         if (c == 0) begin
            idValid = 1'b1; idOpcode = HALT_CODE;
            nameQ.push_back("halt_detect");
            vecQ.push_back(mkExp(CTL_STALL, 1'b0, 1'b0, expStalls));
            expStalls++;
         end else if (c <= 3) begin
            exRedirect = (c == 2);
            if (c == 1) begin
               idValid = 1'b1; idOpcode = HALT_CODE;
               exReadMem = 1'b1; exWriteReg = 1'b1; idUsesRs = 1'b1;
            end
            nameQ.push_back("drain_cycle");
            vecQ.push_back(mkExp(CTL_STALL, 1'b0, 1'b0, expStalls));
         end else begin
            exRedirect = (c == 5);
            memAccess  = (c == 5);
            nameQ.push_back("halted_sticky");
            vecQ.push_back(mkExp(CTL_ZERO, 1'b1, 1'b0, expStalls));
         end
         @(negedge clk);
         nm = nameQ.pop_front();
         ev = vecQ.pop_front();
         checks++;
         if (obsVec !== ev) begin
            failures++;
            $display("[TB] FAIL %s c%0d: got ctl=%b h=%b err=%b st=%0d, expected ctl=%b h=%b err=%b st=%0d",
                     nm, c, obsVec[25:18], obsVec[17], obsVec[16], obsVec[15:0], ev[25:18], ev[17], ev[16], ev[15:0]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_halt_drain_stall();
      string nm;
      logic [25:0] ev;
      doReset();
      for (int c = 0; c < 8; c++) begin
         applyStimulus();
         case (c)
            0: begin
               idValid = 1'b1; idOpcode = HALT_CODE;
               nameQ.push_back("hds_halt_detect");
               vecQ.push_back(mkExp(CTL_STALL, 1'b0, 1'b0, expStalls));
               expStalls++;
            end
            1, 5: begin
               nameQ.push_back("hds_drain");
               vecQ.push_back(mkExp(CTL_STALL, 1'b0, 1'b0, expStalls));
            end
            2: begin
               memAccess = 1'b1; memReady = 1'b0;
               nameQ.push_back("hds_freeze_in_drain");
               vecQ.push_back(mkExp(CTL_ZERO, 1'b0, 1'b0, expStalls));
            end
            3: begin
               memAccess = 1'b1; memReady = 1'b0;
               nameQ.push_back("hds_freeze_mem_wait");
               vecQ.push_back(mkExp(CTL_ZERO, 1'b0, 1'b0, expStalls));
               expStalls++;
            end
            4: begin
               memAccess = 1'b1;
               nameQ.push_back("hds_ready_back_to_drain");
               vecQ.push_back(mkExp(CTL_STALL, 1'b0, 1'b0, expStalls));
               expStalls++;
            end
            default: begin
               nameQ.push_back("hds_halted");
               vecQ.push_back(mkExp(CTL_ZERO, 1'b1, 1'b0, expStalls));
            end
         endcase
         @(negedge clk);
         nm = nameQ.pop_front();
         ev = vecQ.pop_front();
         checks++;
         if (obsVec !== ev) begin
            failures++;
            $display("[TB] FAIL %s c%0d: got ctl=%b h=%b err=%b st=%0d, expected ctl=%b h=%b err=%b st=%0d",
                     nm, c, obsVec[25:18], obsVec[17], obsVec[16], obsVec[15:0], ev[25:18], ev[17], ev[16], ev[15:0]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_timeout_boundary();
      string nm;
      logic [25:0] ev;
      doReset();
      for (int c = 0; c < 17; c++) begin
         applyStimulus();
         memAccess = (c <= 15);
         if (c < 15) begin
            memReady = 1'b0;
            nameQ.push_back("tmo15_freeze");
            vecQ.push_back(mkExp(CTL_ZERO, 1'b0, 1'b0, expStalls));
            expStalls++;
         end else begin
            nameQ.push_back("tmo15_no_error");
            vecQ.push_back(mkExp(CTL_NORM, 1'b0, 1'b0, expStalls));
         end
         @(negedge clk);
         nm = nameQ.pop_front();
         ev = vecQ.pop_front();
         checks++;
         if (obsVec !== ev) begin
            failures++;
            $display("[TB] FAIL %s c%0d: got ctl=%b h=%b err=%b st=%0d, expected ctl=%b h=%b err=%b st=%0d",
                     nm, c, obsVec[25:18], obsVec[17], obsVec[16], obsVec[15:0], ev[25:18], ev[17], ev[16], ev[15:0]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_timeout();
      string nm;
      logic [25:0] ev;
      doReset();
      for (int c = 0; c < 19; c++) begin
         applyStimulus();
         if (c < 16) begin
            memAccess = 1'b1; memReady = 1'b0;
            nameQ.push_back("tmo_freeze");
            vecQ.push_back(mkExp(CTL_ZERO, 1'b0, 1'b0, expStalls));
            expStalls++;
         end else if (c == 16) begin
            memAccess = 1'b1; memReady = 1'b0;
            nameQ.push_back("tmo_error_halted");
            vecQ.push_back(mkExp(CTL_ZERO, 1'b1, 1'b1, expStalls));
         end else if (c == 17) begin
            rst_n = 1'b0;
            expStalls = 16'd0;
            nameQ.push_back("tmo_reset_clears");
            vecQ.push_back(mkExp(CTL_ZERO, 1'b0, 1'b0, expStalls));
         end else begin
            rst_n = 1'b1;
            nameQ.push_back("tmo_run_after_reset");
            vecQ.push_back(mkExp(CTL_NORM, 1'b0, 1'b0, expStalls));
         end
         @(negedge clk);
         nm = nameQ.pop_front();
         ev = vecQ.pop_front();
         checks++;
         if (obsVec !== ev) begin
            failures++;
            $display("[TB] FAIL %s c%0d: got ctl=%b h=%b err=%b st=%0d, expected ctl=%b h=%b err=%b st=%0d",
                     nm, c, obsVec[25:18], obsVec[17], obsVec[16], obsVec[15:0], ev[25:18], ev[17], ev[16], ev[15:0]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus();
      #1;
      $display("[TB] starting pipeline_ctrl scenarios");
      test_reset();
      test_load_use();
      test_redirect();
      test_mem_wait();
      test_halt_drain();
      test_halt_drain_stall();
      test_timeout_boundary();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
